// File: rtl/pc_gen.sv
// Fetch-stage program counter: boot handshake, halt/resume, and next-PC selection
// among trap, mret, branch, JALR, stall and sequential sources with alignment checks.
module pc_gen #(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_VEC = '0,
  parameter logic [31:0]      TRAP_VEC  = 32'h0000_0100,
  parameter int               IALIGN    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            boot_up,
  input  logic            resume,
  input  logic            halt_req,
  input  logic            trap_req,
  input  logic            mret_req,
  input  logic            branch_valid,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jalr_valid,
  input  logic [XLEN-1:0] jalr_target,
  input  logic            keep_pc,
  output logic [XLEN-1:0] pc,
  output logic            pc_running,
  output logic [XLEN-1:0] epc,
  output logic            misalign_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  localparam logic [XLEN-1:0] TRAP_ADDR = XLEN'(TRAP_VEC);
  localparam logic [XLEN-1:0] STEP      = XLEN'(IALIGN);
  localparam logic [XLEN-1:0] BIT0_MASK = {{(XLEN-1){1'b0}}, 1'b1};

  logic [1:0]      state_r;
  logic [1:0]      state_next_s;
  logic [XLEN-1:0] pc_next_s;
  logic [XLEN-1:0] epc_next_s;
  logic            misalign_next_s;
  logic [XLEN-1:0] jalr_addr_s;

  // With 4-byte alignment bit 1 flags a fault; with 2-byte alignment bit 0 does.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    if (IALIGN == 4) begin
      is_misaligned = addr[1];
    end else begin
      is_misaligned = addr[0];
    end
  endfunction

  assign jalr_addr_s = jalr_target & ~BIT0_MASK;

  // Next state and next PC/EPC selection
  always_comb begin
    state_next_s    = state_r;
    pc_next_s       = pc;
    epc_next_s      = epc;
    misalign_next_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        pc_next_s = RESET_VEC;
        if (boot_up) state_next_s = ST_LOAD;
        else         state_next_s = ST_IDLE;
      end
      ST_LOAD: begin
        pc_next_s = RESET_VEC;
        if (!boot_up) state_next_s = ST_RUN;
        else          state_next_s = ST_LOAD;
      end
      ST_RUN: begin
        if (halt_req) state_next_s = ST_HALT;
        else          state_next_s = ST_RUN;
        if (trap_req) begin
          pc_next_s  = TRAP_ADDR;
          epc_next_s = pc;
        end else if (mret_req) begin
          pc_next_s = epc;
        end else if (branch_valid) begin
          if (is_misaligned(branch_target)) begin
            pc_next_s       = TRAP_ADDR;
            epc_next_s      = branch_target;
            misalign_next_s = 1'b1;
          end else begin
            pc_next_s = branch_target;
          end
        end else if (jalr_valid) begin
          if (is_misaligned(jalr_addr_s)) begin
            pc_next_s       = TRAP_ADDR;
            epc_next_s      = jalr_addr_s;
            misalign_next_s = 1'b1;
          end else begin
            pc_next_s = jalr_addr_s;
          end
        end else if (keep_pc) begin
          pc_next_s = pc;
        end else begin
          pc_next_s = pc + STEP;
        end
      end
      ST_HALT: begin
        if (resume) state_next_s = ST_RUN;
        else        state_next_s = ST_HALT;
      end
      default: begin
        state_next_s = ST_IDLE;
        pc_next_s    = RESET_VEC;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      pc           <= RESET_VEC;
      epc          <= '0;
      pc_running   <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      pc           <= pc_next_s;
      epc          <= epc_next_s;
      pc_running   <= (state_next_s == ST_RUN);
      misalign_err <= misalign_next_s;
    end
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage, and the successor to the fixed 32-bit PC register. It runs a boot handshake, then selects the next fetch address from trap, exception-return, branch, JALR, stall and sequential sources. It adds features the earlier PC lacked: internal increment, a configurable reset vector, trap and `mret` redirection with an EPC register, target-alignment checking, and a halt/resume state.

## Interface
Parameters:
- XLEN, 32, address width in bits (legal: 32 or 64).
- RESET_VEC, 0, PC value while not running and after reset.
- TRAP_VEC, 32'h0000_0100, trap handler address (zero-extended to XLEN).
- IALIGN, 4, instruction alignment in bytes (legal: 2 or 4); also the sequential increment.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- boot_up  in  1  boot handshake level from the loader.
- resume  in  1  leave HALT.
- halt_req  in  1  enter HALT.
- trap_req  in  1  take a trap.
- mret_req  in  1  return from trap to EPC.
- branch_valid  in  1  branch resolved taken in MEM.
- branch_target  in  XLEN  branch destination.
- jalr_valid  in  1  JALR in MEM.
- jalr_target  in  XLEN  raw ALU sum for the JALR; bit 0 is cleared internally.
- keep_pc  in  1  stall: hold the PC.
- pc  out  XLEN  current fetch address, registered.
- pc_running  out  1  high only in RUN.
- epc  out  XLEN  PC captured at the last trap, registered.
- misalign_err  out  1  one-cycle pulse when a redirect target was misaligned.

## Operation
- FSM states: IDLE, LOAD, RUN, HALT. Reset state is IDLE.
- IDLE -> LOAD when boot_up=1.
- LOAD -> RUN when boot_up=0.
- RUN -> HALT when halt_req=1.
- HALT -> RUN when resume=1. All other cases hold the current state.
- In IDLE and LOAD, pc is forced to RESET_VEC every cycle.
- In HALT, pc is held. trap_req, mret_req, branch_valid and jalr_valid are ignored.
- In RUN, the next pc is the first true source in this priority order:
  1. trap_req: pc <= TRAP_VEC; epc <= pc.
  2. mret_req: pc <= epc.
  3. branch_valid: pc <= branch_target.
  4. jalr_valid: pc <= {jalr_target[XLEN-1:1], 1'b0}.
  5. keep_pc: pc <= pc.
  6. Otherwise: pc <= pc + IALIGN, modulo 2^XLEN (wraps to 0 from the top).
- Alignment check applies to the selected branch or JALR target only:
  - A target is misaligned if bit 1 is set and IALIGN=4. With IALIGN=2, JALR can never misalign after bit 0 is cleared, and a branch target misaligns if bit 0 is set.
  - On a misaligned target, behave as a trap: pc <= TRAP_VEC, epc <= address of the faulting target, misalign_err=1 for exactly one cycle.
- halt_req together with a redirect in the same RUN cycle: the redirect updates pc on that edge and the state becomes HALT; pc then holds the redirected value.
- mret_req also returns to epc after HALT->RUN. epc is never modified outside trap or misalign events.

## Timing
- All outputs are registered. Any request sampled at edge N is visible on pc at edge N, i.e. one cycle after it was presented.
- Reset values: pc=RESET_VEC, epc=0, pc_running=0, misalign_err=0, state=IDLE.
- Asserting rst_n low at any time, including mid-RUN or mid-redirect, immediately forces those values.
- RUN is entered on the first edge after boot_up falls while in LOAD. That cycle pc=RESET_VEC and pc_running=1.
- The first increment occurs on the following edge.
- keep_pc has the lowest redirect priority: a branch or trap overrides a stall.
- misalign_err goes high on the same edge that pc is set to TRAP_VEC and drops on the next edge, unless another misalign occurs.

## Test plan
- Boot: reset, boot_up=1 for 3 cycles then 0 -> pc=RESET_VEC throughout, pc_running rises on exit from LOAD, then pc steps 0,4,8,... (XLEN=32, IALIGN=4).
- Priority: in one cycle assert trap_req, branch_valid (target 0x200) and keep_pc with pc=0x40 -> pc=0x100, epc=0x40. Next cycle mret_req -> pc=0x40.
- JALR and misalign: jalr_target=0x305 -> pc=0x304. branch_target=0x302 with IALIGN=4 -> pc=0x100, epc=0x302, misalign_err high for 1 cycle.
- Stall and wrap: keep_pc for 4 cycles at pc=0x20 -> pc holds 0x20. Reaching pc=0xFFFF_FFFC with no redirect -> next pc=0x0.
- Halt: halt_req with branch_valid (target 0x80) -> pc=0x80, state HALT, pc_running=0. trap_req during HALT is ignored. resume -> pc_running=1, pc=0x84 on the next edge.
- Async reset: drop rst_n between edges while in RUN with pc=0x1234 -> pc=RESET_VEC and pc_running=0 without waiting for a clock edge; the boot handshake is then required again.
